// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the virtual-channel arbiter.
//   - Status state encodings driven on vc_arbiter.state.
//   - Default word width, matching the upstream VC FIFOs.
package vc_arbiter_pkg;

  localparam int DATA_WIDTH_DEFAULT = 6;

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_PAUSE  = 2'd3;

endpackage

// File: rtl/vc_arbiter.sv
// vc_arbiter: pops words from the VC0/VC1 FIFOs (strict priority, VC0 first)
// and routes each word to destination FIFO D0 or D1 based on bit DEST_BIT.
//
// Ports:
//   clk                      clock, all state on posedge
//   reset                    synchronous active-low reset
//   init                     active-high enable; low acts like reset
//   empty_fifo_VC0/VC1       upstream empty flags
//   data_out_VC0/VC1         upstream registered read data
//   almost_full_fifo_D0/D1   downstream backpressure (combined into one stall)
//   pop_VC0/VC1              upstream read enables (combinational)
//   push_D0/D1               downstream write enables (registered)
//   data_out_D0/D1           downstream write data (registered, held)
//   state                    status: RESET/IDLE/ACTIVE/PAUSE (registered)
//   idle                     state == IDLE
//
// Latency: pop in cycle t, upstream data valid in t+1, push in t+2.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEFAULT,
  parameter int DEST_BIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [data_width-1:0] data_out_VC0,
  input  logic [data_width-1:0] data_out_VC1,
  input  logic                  almost_full_fifo_D0,
  input  logic                  almost_full_fifo_D1,
  output logic                  pop_VC0,
  output logic                  pop_VC1,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [data_width-1:0] data_out_D0,
  output logic [data_width-1:0] data_out_D1,
  output logic [1:0]            state,
  output logic                  idle
);

  logic                  run;
  logic                  af;
  logic                  both_empty;
  logic                  pv;        // a pop was issued last cycle
  logic                  psrc;      // 0: that pop was VC0, 1: VC1
  logic [data_width-1:0] sel_word;
  logic [1:0]            state_next;

  assign run        = reset & init;
  assign af         = almost_full_fifo_D0 | almost_full_fifo_D1;
  assign both_empty = empty_fifo_VC0 & empty_fifo_VC1;

  // Backpressure stops pops in the same cycle; the two words already in
  // flight still complete, which is why downstream needs >= 2 spare entries.
  assign pop_VC0 = run & ~af & ~empty_fifo_VC0;
  assign pop_VC1 = run & ~af & empty_fifo_VC0 & ~empty_fifo_VC1;

  assign sel_word = psrc ? data_out_VC1 : data_out_VC0;
  assign idle     = (state == ST_IDLE);

  // Pop/route pipeline.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!run) begin
      pv          <= 1'b0;
      psrc        <= 1'b0;
      push_D0     <= 1'b0;
      push_D1     <= 1'b0;
      data_out_D0 <= '0;
      data_out_D1 <= '0;
    end else begin
      pv      <= pop_VC0 | pop_VC1;
      psrc    <= pop_VC1;
      push_D0 <= 1'b0;
      push_D1 <= 1'b0;
      if (pv) begin
        if (sel_word[DEST_BIT]) begin
          push_D1     <= 1'b1;
          data_out_D1 <= sel_word;
        end else begin
          push_D0     <= 1'b1;
          data_out_D0 <= sel_word;
        end
      end
    end
  end

  // Status state machine.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  state_next = ST_IDLE;
      ST_IDLE: begin
        if (af)               state_next = ST_PAUSE;
        else if (!both_empty) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (af)                     state_next = ST_PAUSE;
        else if (both_empty && !pv) state_next = ST_IDLE;
      end
      ST_PAUSE: begin
        if (!af) state_next = both_empty ? ST_IDLE : ST_ACTIVE;
      end
      default:   state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!run) state <= ST_RESET;
    else      state <= state_next;
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed testbench for vc_arbiter. Two small behavioural VC FIFOs with
// registered read data feed the DUT; each scenario task steps the clock,
// drives inputs on the falling edge and compares outputs against
// hand-computed per-cycle tables.
module tb_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset, init;
  logic       empty_fifo_VC0, empty_fifo_VC1;
  logic [5:0] data_out_VC0, data_out_VC1;
  logic       almost_full_fifo_D0, almost_full_fifo_D1;
  logic       pop_VC0, pop_VC1, push_D0, push_D1;
  logic [5:0] data_out_D0, data_out_D1;
  logic [1:0] state;
  logic       idle;

  int errors = 0;
  int checks = 0;

  vc_arbiter #(.data_width(6), .DEST_BIT(4)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_fifo_VC0(empty_fifo_VC0), .empty_fifo_VC1(empty_fifo_VC1),
    .data_out_VC0(data_out_VC0), .data_out_VC1(data_out_VC1),
    .almost_full_fifo_D0(almost_full_fifo_D0), .almost_full_fifo_D1(almost_full_fifo_D1),
    .pop_VC0(pop_VC0), .pop_VC1(pop_VC1), .push_D0(push_D0), .push_D1(push_D1),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .state(state), .idle(idle)
  );

  always #5 clk = ~clk;

  // Upstream VC FIFO models: registered read data, flushed on reset/init.
  logic [5:0] mem0 [16];
  logic [5:0] mem1 [16];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;

  assign empty_fifo_VC0 = (rd0 == wr0);
  assign empty_fifo_VC1 = (rd1 == wr1);

  always @(posedge clk) begin
    if (!(reset && init)) begin
      rd0 <= wr0; rd1 <= wr1;
      data_out_VC0 <= '0; data_out_VC1 <= '0;
    end else begin
      if (pop_VC0) begin data_out_VC0 <= mem0[rd0 % 16]; rd0 <= rd0 + 1; end
      if (pop_VC1) begin data_out_VC1 <= mem1[rd1 % 16]; rd1 <= rd1 + 1; end
    end
  end

  task automatic load0(input logic [5:0] w);
    mem0[wr0 % 16] = w; wr0 = wr0 + 1;
  endtask

  task automatic load1(input logic [5:0] w);
    mem1[wr1 % 16] = w; wr1 = wr1 + 1;
  endtask

  task automatic test_reset;
    reset = 1'b0; init = 1'b1;
    almost_full_fifo_D0 = 1'b0; almost_full_fifo_D1 = 1'b0;
    load0(6'h05); load1(6'h23);
    #1;
    checks++;
    if ({pop_VC0, pop_VC1} !== 2'b00) begin
      errors++; $display("FAIL reset pops: got %b want 00", {pop_VC0, pop_VC1});
    end
    @(negedge clk);
    checks++;
    if ({push_D0, push_D1} !== 2'b00) begin
      errors++; $display("FAIL reset pushes: got %b want 00", {push_D0, push_D1});
    end
    checks++;
    if ({data_out_D0, data_out_D1} !== 12'h000) begin
      errors++; $display("FAIL reset data: got %h/%h want 00/00", data_out_D0, data_out_D1);
    end
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL reset state: got %0d want 0", state);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL reset state_held: got %0d want 0", state);
    end
    @(negedge clk);
    #1;
    checks++;
    if (state !== 2'd1 || idle !== 1'b1) begin
      errors++; $display("FAIL reset to_idle: got state=%0d idle=%b want 1/1", state, idle);
    end
  endtask

  // Expected control vector per cycle is {pop_VC0, pop_VC1, push_D0, push_D1}.
  task automatic test_priority;
    logic [3:0] e_ctl [6] = '{4'b1000, 4'b1000, 4'b0110, 4'b0001, 4'b0010, 4'b0000};
    logic [5:0] e_d0  [6] = '{6'h00, 6'h00, 6'h05, 6'h05, 6'h23, 6'h23};
    logic [5:0] e_d1  [6] = '{6'h00, 6'h00, 6'h00, 6'h15, 6'h15, 6'h15};
    logic [1:0] e_st  [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin load0(6'h05); load0(6'h15); load1(6'h23); end
      #1;
      checks++;
      if ({pop_VC0, pop_VC1, push_D0, push_D1} !== e_ctl[k]) begin
        errors++; $display("FAIL prio ctl cyc%0d: got %b want %b", k, {pop_VC0, pop_VC1, push_D0, push_D1}, e_ctl[k]);
      end
      checks++;
      if (data_out_D0 !== e_d0[k] || data_out_D1 !== e_d1[k]) begin
        errors++; $display("FAIL prio data cyc%0d: got %h/%h want %h/%h", k, data_out_D0, data_out_D1, e_d0[k], e_d1[k]);
      end
      checks++;
      if (state !== e_st[k]) begin
        errors++; $display("FAIL prio state cyc%0d: got %0d want %0d", k, state, e_st[k]);
      end
    end
  endtask

  task automatic test_routing;
    logic [3:0] e_ctl [6] = '{4'b0100, 4'b0100, 4'b0101, 4'b0010, 4'b0001, 4'b0000};
    logic [5:0] e_d0  [6] = '{6'h23, 6'h23, 6'h23, 6'h01, 6'h01, 6'h01};
    logic [5:0] e_d1  [6] = '{6'h15, 6'h15, 6'h10, 6'h10, 6'h3F, 6'h3F};
    logic [1:0] e_st  [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin load1(6'h10); load1(6'h01); load1(6'h3F); end
      #1;
      checks++;
      if ({pop_VC0, pop_VC1, push_D0, push_D1} !== e_ctl[k]) begin
        errors++; $display("FAIL route ctl cyc%0d: got %b want %b", k, {pop_VC0, pop_VC1, push_D0, push_D1}, e_ctl[k]);
      end
      checks++;
      if (data_out_D0 !== e_d0[k] || data_out_D1 !== e_d1[k]) begin
        errors++; $display("FAIL route data cyc%0d: got %h/%h want %h/%h", k, data_out_D0, data_out_D1, e_d0[k], e_d1[k]);
      end
      checks++;
      if (state !== e_st[k]) begin
        errors++; $display("FAIL route state cyc%0d: got %0d want %0d", k, state, e_st[k]);
      end
    end
  endtask

  // Six VC0 words; almost_full_fifo_D1 is high for cycles 2..4.
  task automatic test_backpressure;
    logic [3:0] e_ctl [12] = '{4'b1000, 4'b1000, 4'b0010, 4'b0001, 4'b0000, 4'b1000,
                               4'b1000, 4'b1010, 4'b1001, 4'b0010, 4'b0001, 4'b0000};
    logic [5:0] e_d0  [12] = '{6'h01, 6'h01, 6'h01, 6'h01, 6'h01, 6'h01,
                               6'h01, 6'h03, 6'h03, 6'h05, 6'h05, 6'h05};
    logic [5:0] e_d1  [12] = '{6'h3F, 6'h3F, 6'h3F, 6'h12, 6'h12, 6'h12,
                               6'h12, 6'h12, 6'h14, 6'h14, 6'h16, 6'h16};
    logic [1:0] e_st  [12] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3,
                               2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        load0(6'h01); load0(6'h12); load0(6'h03);
        load0(6'h14); load0(6'h05); load0(6'h16);
      end
      if (k == 2) almost_full_fifo_D1 = 1'b1;
      if (k == 5) almost_full_fifo_D1 = 1'b0;
      #1;
      checks++;
      if ({pop_VC0, pop_VC1, push_D0, push_D1} !== e_ctl[k]) begin
        errors++; $display("FAIL bp ctl cyc%0d: got %b want %b", k, {pop_VC0, pop_VC1, push_D0, push_D1}, e_ctl[k]);
      end
      checks++;
      if (data_out_D0 !== e_d0[k] || data_out_D1 !== e_d1[k]) begin
        errors++; $display("FAIL bp data cyc%0d: got %h/%h want %h/%h", k, data_out_D0, data_out_D1, e_d0[k], e_d1[k]);
      end
      checks++;
      if (state !== e_st[k]) begin
        errors++; $display("FAIL bp state cyc%0d: got %0d want %0d", k, state, e_st[k]);
      end
    end
  endtask

  task automatic test_drain;
    logic [3:0] e_ctl  [5] = '{4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    logic [5:0] e_d0   [5] = '{6'h05, 6'h05, 6'h2A, 6'h2A, 6'h2A};
    logic [1:0] e_st   [5] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
    logic       e_idle [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) load0(6'h2A);
      #1;
      checks++;
      if ({pop_VC0, pop_VC1, push_D0, push_D1} !== e_ctl[k]) begin
        errors++; $display("FAIL drain ctl cyc%0d: got %b want %b", k, {pop_VC0, pop_VC1, push_D0, push_D1}, e_ctl[k]);
      end
      checks++;
      if (data_out_D0 !== e_d0[k] || data_out_D1 !== 6'h16) begin
        errors++; $display("FAIL drain data cyc%0d: got %h/%h want %h/16", k, data_out_D0, data_out_D1, e_d0[k]);
      end
      checks++;
      if (state !== e_st[k] || idle !== e_idle[k]) begin
        errors++; $display("FAIL drain state cyc%0d: got %0d/%b want %0d/%b", k, state, idle, e_st[k], e_idle[k]);
      end
    end
  endtask

  // almost_full_fifo_D0 rises in the same cycle a word lands in VC1.
  task automatic test_af_with_empty;
    logic [3:0] e_ctl [6] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
    logic [5:0] e_d1  [6] = '{6'h16, 6'h16, 6'h16, 6'h16, 6'h11, 6'h11};
    logic [1:0] e_st  [6] = '{2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin almost_full_fifo_D0 = 1'b1; load1(6'h11); end
      if (k == 2) almost_full_fifo_D0 = 1'b0;
      #1;
      checks++;
      if ({pop_VC0, pop_VC1, push_D0, push_D1} !== e_ctl[k]) begin
        errors++; $display("FAIL af_empty ctl cyc%0d: got %b want %b", k, {pop_VC0, pop_VC1, push_D0, push_D1}, e_ctl[k]);
      end
      checks++;
      if (data_out_D0 !== 6'h2A || data_out_D1 !== e_d1[k]) begin
        errors++; $display("FAIL af_empty data cyc%0d: got %h/%h want 2A/%h", k, data_out_D0, data_out_D1, e_d1[k]);
      end
      checks++;
      if (state !== e_st[k]) begin
        errors++; $display("FAIL af_empty state cyc%0d: got %0d want %0d", k, state, e_st[k]);
      end
    end
  endtask

  // init drops for one cycle (cycle 3) while words are in flight.
  task automatic test_init_drop;
    logic [3:0] e_ctl [6] = '{4'b1000, 4'b1000, 4'b1010, 4'b0010, 4'b0000, 4'b0000};
    logic [5:0] e_d0  [6] = '{6'h2A, 6'h2A, 6'h07, 6'h08, 6'h00, 6'h00};
    logic [5:0] e_d1  [6] = '{6'h11, 6'h11, 6'h11, 6'h11, 6'h00, 6'h00};
    logic [1:0] e_st  [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin load0(6'h07); load0(6'h08); load0(6'h09); load0(6'h0A); end
      if (k == 3) init = 1'b0;
      if (k == 4) init = 1'b1;
      #1;
      checks++;
      if ({pop_VC0, pop_VC1, push_D0, push_D1} !== e_ctl[k]) begin
        errors++; $display("FAIL init ctl cyc%0d: got %b want %b", k, {pop_VC0, pop_VC1, push_D0, push_D1}, e_ctl[k]);
      end
      checks++;
      if (data_out_D0 !== e_d0[k] || data_out_D1 !== e_d1[k]) begin
        errors++; $display("FAIL init data cyc%0d: got %h/%h want %h/%h", k, data_out_D0, data_out_D1, e_d0[k], e_d1[k]);
      end
      checks++;
      if (state !== e_st[k]) begin
        errors++; $display("FAIL init state cyc%0d: got %0d want %0d", k, state, e_st[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_priority;
    test_routing;
    test_backpressure;
    test_drain;
    test_af_with_empty;
    test_init_drop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

- Consumes words from the VC0 and VC1 FIFOs and routes them to destination FIFOs D0 and D1.
- Sits directly downstream of the VC FIFOs: drives their read enables and samples their registered data_out.
- Arbitration is strict priority, VC0 over VC1. The destination is chosen per word from one data bit.
- A status state machine reports idle, active and paused (backpressure) operation.

## Interface
Parameters:
- data_width, 6, word width; matches the VC FIFOs.
- DEST_BIT, 4, bit index selecting the destination (0 → D0, 1 → D1).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; 0 resets the block at the next posedge.
- init  in  1  active-high enable; init=0 behaves exactly like reset=0.
- empty_fifo_VC0, empty_fifo_VC1  in  1 each  upstream empty flags.
- data_out_VC0, data_out_VC1  in  data_width each  upstream registered read data.
- almost_full_fifo_D0, almost_full_fifo_D1  in  1 each  downstream backpressure.
- pop_VC0, pop_VC1  out  1 each  read enables to the VC FIFOs (combinational).
- push_D0, push_D1  out  1 each  write enables to D0/D1 (registered).
- data_out_D0, data_out_D1  out  data_width each  write data to D0/D1 (registered).
- state  out  2  arbiter status (registered).
- idle  out  1  high when state == IDLE (combinational decode of state).

## Operation
Definitions:
- run = reset & init
- af = almost_full_fifo_D0 | almost_full_fifo_D1

Pop logic (combinational):
- pop_VC0 = run & ~af & ~empty_fifo_VC0
- pop_VC1 = run & ~af & empty_fifo_VC0 & ~empty_fifo_VC1
- At most one pop per cycle. VC1 is served only while VC0 is empty, so VC1 starvation is accepted.

Pipeline:
- A registered valid/source pair, pv and psrc, captures each pop.
- Next cycle, if pv=1, the word is taken from data_out_VC0 or data_out_VC1 according to psrc.
- Bit DEST_BIT of that word selects the destination. The full word is registered into data_out_Dx, and push_Dx=1 for one cycle.
- The non-selected push is 0. Both data outputs hold their last value when not pushing.
- A word already in the pipeline completes its push even if af rises; no words are lost or duplicated.

State machine (registered; encodings RESET=0, IDLE=1, ACTIVE=2, PAUSE=3):
- Any state with run=0 → RESET.
- RESET → IDLE when run=1.
- IDLE → PAUSE if af; → ACTIVE if any VC is non-empty; otherwise stay.
- ACTIVE → PAUSE if af; → IDLE if both VCs are empty and pv=0; otherwise stay.
- PAUSE → IDLE when ~af and both VCs are empty; → ACTIVE when ~af and a VC is non-empty.

## Timing
Reset:
- Every register is cleared at the posedge where run=0: state=RESET, pv=0, psrc=0, push_D0=push_D1=0, data_out_D0=data_out_D1=0.
- pop_VC0=pop_VC1=0 while run=0.
- Reset mid-transfer discards in-flight words. The VC FIFOs reset in the same cycle, so this is consistent.

Latency:
- pop asserted in cycle t → upstream data_out valid in t+1 → push_Dx/data_out_Dx valid in t+2.
- Throughput is one word per cycle while unblocked.

Backpressure:
- af is sampled combinationally; pops stop in the same cycle af rises.
- Up to 2 words remain in flight after af rises. Destination FIFOs must assert almost_full with ≥2 free entries (Umbral ≥ 2).

Boundary conditions:
- Last word: pop while cnt=1; upstream empty rises next cycle; no extra pop is issued.
- Simultaneous VC0 and VC1 non-empty: VC0 is popped.
- af and empty changing in the same cycle: af dominates (no pop).
- Both destination almost_full flags are treated as one combined stall. There is no per-destination skipping, which preserves order.

## Structure
- Shared package holds:
  - the state encodings (RESET, IDLE, ACTIVE, PAUSE);
  - the default data_width.
- Single module, no sub-modules.
- The pop/route pipeline and the state machine live in separate always blocks.

## Test plan
- Reset: reset=0 for 2 cycles with both VCs non-empty → no pops, push=0, data_out=0, state=0; after reset=1, init=1 → state=1 next cycle.
- Priority: VC0 holds 0x05 and 0x15, VC1 holds 0x23 → push sequence D0:0x05, D1:0x15, D0:0x23 on consecutive cycles, starting 2 cycles after the first pop.
- Routing: VC1-only stream 0x10, 0x01, 0x3F → push_D1 for 0x10 and 0x3F, push_D0 for 0x01; no pop_VC0.
- Backpressure: almost_full_fifo_D1 rises during a 6-word VC0 burst → pops stop the same cycle, ≤2 further pushes occur, state=3; af falls → pops resume, state=2, and all 6 words arrive in order.
- Drain to idle: the last word is popped → exactly one push follows, state returns to 1, idle=1, pop stays 0.
- init drop mid-burst: init=0 for 1 cycle → pipeline cleared, no push in the following cycle, state=0 then 1.
